// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and period counter feeding per-channel double-buffered duty comparators.
// Define PWM_CENTER_ALIGN_EN for an up/down (triangle) counter; default build is edge-aligned sawtooth.

module pwm_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic             commit,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] period_a,
    input  logic             dir_up,
    output logic             pwm
);
    logic [WIDTH-1:0] duty_s, duty_a;
    logic             hi;

`ifdef PWM_CENTER_ALIGN_EN
    logic [WIDTH:0] sum;

    // High while cnt sits within duty of the top; the down ramp takes one extra
    // step so both ramps contribute duty ticks each.
    always_comb begin
        sum = {1'b0, cnt} + {1'b0, duty_a};
        hi  = (duty_a != '0) &&
              ((duty_a >= period_a) ||
               (sum > {1'b0, period_a}) ||
               (!dir_up && (sum == {1'b0, period_a})));
    end
`else
    logic unused_lane;
    assign unused_lane = dir_up | (|period_a);
    assign hi = (cnt < duty_a);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_s <= '0;
            duty_a <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load)
                duty_s <= duty_in;
            // A load landing on the commit cycle bypasses the shadow.
            if (commit)
                duty_a <= load ? duty_in : duty_s;
            pwm <= enable & hi;
        end
    end
endmodule

module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      load_ack
);
    logic [PRESC_W-1:0] presc_cnt;
    logic [WIDTH-1:0]   cnt, cnt_nxt, period_a, period_s;
    logic               dir_up, dir_nxt, pending;
    logic               tick, wrap_tick, commit;

    // >= keeps the prescaler sane if prescale is lowered below presc_cnt live.
    assign tick = enable && (presc_cnt >= prescale);

`ifdef PWM_CENTER_ALIGN_EN
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir_up;
        if (period_a == '0) begin
            cnt_nxt = '0;
        end else if (dir_up) begin
            if (cnt >= period_a) begin
                cnt_nxt = cnt - 1'b1;
                dir_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            cnt_nxt = (cnt <= 1) ? '0 : cnt - 1'b1;
        end
        if (cnt_nxt == '0)
            dir_nxt = 1'b1;
    end
`else
    always_comb begin
        cnt_nxt = (cnt >= period_a) ? '0 : cnt + 1'b1;
        dir_nxt = 1'b1;
    end
`endif

    assign wrap_tick = tick && (cnt_nxt == '0);
    // While stopped there is no period to protect, so a pending load commits at once.
    assign commit    = (pending || load) && (wrap_tick || !enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt  <= '0;
            cnt        <= '0;
            dir_up     <= 1'b1;
            period_a   <= '1;
            period_s   <= '0;
            pending    <= 1'b0;
            period_end <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            if (!enable) begin
                presc_cnt <= '0;
                cnt       <= '0;
                dir_up    <= 1'b1;
            end else if (tick) begin
                presc_cnt <= '0;
                cnt       <= cnt_nxt;
                dir_up    <= dir_nxt;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end

            if (load)
                period_s <= period;
            if (commit) begin
                period_a <= load ? period : period_s;
                pending  <= 1'b0;
            end else if (load) begin
                pending  <= 1'b1;
            end

            period_end <= wrap_tick;
            load_ack   <= commit;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .load    (load),
            .commit  (commit),
            .duty_in (duty[i*WIDTH +: WIDTH]),
            .cnt     (cnt),
            .period_a(period_a),
            .dir_up  (dir_up),
            .pwm     (pwm_out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: per-period records (length, high counts, ack) against a scoreboard queue.
// Build with PWM_CENTER_ALIGN_EN defined to exercise the triangle counter instead.

module tb_pwm_multi_channel;
    localparam int WIDTH    = 4;
    localparam int CHANNELS = 2;
    localparam int PRESC_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      enable = 1'b0;
    logic                      load = 1'b0;
    logic [PRESC_W-1:0]        prescale = '0;
    logic [WIDTH-1:0]          period = '0;
    logic [CHANNELS*WIDTH-1:0] duty = '0;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_end, load_ack;

    typedef struct {
        int len;
        int hi0;
        int hi1;
        int ack;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_total = 0;
    int   m_len = 0, m_hi0 = 0, m_hi1 = 0;
    bit   en_q = 1'b0;

    always #5 clk = ~clk;

    pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESC_W(PRESC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .prescale  (prescale),
        .period    (period),
        .duty      (duty),
        .load      (load),
        .pwm_out   (pwm_out),
        .period_end(period_end),
        .load_ack  (load_ack)
    );

    // Window per record: samples after one period_end up to and including the next.
    always @(negedge clk) begin
        rec_t r;
        if (load_ack) ack_total++;
        if (!rst_n || !enable) begin
            m_len = 0; m_hi0 = 0; m_hi1 = 0; en_q = 1'b0;
        end else begin
            if (en_q) begin
                m_len++;
                m_hi0 += int'(pwm_out[0]);
                m_hi1 += int'(pwm_out[1]);
                if (period_end) begin
                    r.len = m_len; r.hi0 = m_hi0; r.hi1 = m_hi1; r.ack = int'(load_ack);
                    obs_q.push_back(r);
                    m_len = 0; m_hi0 = 0; m_hi1 = 0;
                end
            end
            en_q = 1'b1;
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int len, input int h0, input int h1, input int ack);
        rec_t e;
        e.len = len; e.hi0 = h0; e.hi1 = h1; e.ack = ack;
        exp_q.push_back(e);
    endtask

    task automatic wait_rec(output bit ok);
        int t = 0;
        while (obs_q.size() == 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        ok = (obs_q.size() != 0);
    endtask

    task automatic drain(input string tag);
        rec_t e, o;
        bit ok;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            wait_rec(ok);
            if (!ok) begin
                chk({tag, " timeout"}, obs_q.size(), 1);
            end else begin
                o = obs_q.pop_front();
                chk({tag, " len"}, o.len, e.len);
                chk({tag, " hi0"}, o.hi0, e.hi0);
                chk({tag, " hi1"}, o.hi1, e.hi1);
                chk({tag, " ack"}, o.ack, e.ack);
            end
        end
    endtask

    task automatic skip(input string tag, input int n);
        bit ok;
        rec_t o;
        for (int i = 0; i < n; i++) begin
            wait_rec(ok);
            if (!ok) chk({tag, " skip timeout"}, obs_q.size(), 1);
            else o = obs_q.pop_front();
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d1,
                           input logic [WIDTH-1:0] d0);
        period = p;
        duty   = {d1, d0};
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int quiet;
        #2 rst_n = 1'b0;
        cyc(3);
        chk("reset pwm_out", int'(pwm_out), 0);
        chk("reset period_end", int'(period_end), 0);
        chk("reset load_ack", int'(load_ack), 0);
        rst_n = 1'b1;

`ifdef PWM_CENTER_ALIGN_EN
        do_load(4'd4, 4'd0, 4'd2);
        chk("stopped commit ack", int'(load_ack), 1);
        enable = 1'b1;
        push(8, 4, 0, 0);
        push(8, 4, 0, 0);
        drain("center d2");
        do_load(4'd4, 4'd0, 4'd5);
        skip("center clamp", 1);
        push(8, 8, 0, 0);
        drain("center clamp");
`else
        // Loaded while stopped: commits immediately, then a clean start.
        do_load(4'd9, 4'd0, 4'd3);
        chk("stopped commit ack", int'(load_ack), 1);
        enable = 1'b1;
        push(10, 3, 0, 0);
        push(10, 3, 0, 0);
        drain("duty 3/10");

        prescale = 8'd2;
        do_load(4'd9, 4'd0, 4'd10);
        skip("presc", 1);
        push(30, 30, 0, 0);
        push(30, 30, 0, 0);
        drain("saturate presc2");

        prescale = 8'd0;
        do_load(4'd9, 4'd0, 4'd3);
        skip("restore", 1);

        // Mid-period load must not disturb the running period.
        cyc(3);
        do_load(4'd9, 4'd4, 4'd7);
        push(10, 3, 0, 1);
        push(10, 7, 4, 0);
        drain("glitch free");

        a0 = ack_total;
        cyc(1);
        do_load(4'd9, 4'd4, 4'd5);
        cyc(1);
        do_load(4'd9, 4'd4, 4'd2);
        push(10, 7, 4, 1);
        push(10, 2, 4, 0);
        drain("double load");
        chk("double load ack count", ack_total - a0, 1);

        // Load presented exactly on the wrap tick (cnt==9).
        repeat (8) @(posedge clk);
        #1;
        do_load(4'd9, 4'd4, 4'd6);
        push(10, 2, 4, 1);
        push(10, 6, 4, 0);
        drain("wrap load");

        cyc(3);
        chk("pre-disable ch0 high", int'(pwm_out[0]), 1);
        enable = 1'b0;
        cyc(1);
        chk("disable pwm_out", int'(pwm_out), 0);
        quiet = 0;
        repeat (12) begin
            cyc(1);
            quiet |= int'(period_end) | int'(|pwm_out);
        end
        chk("disabled quiet", quiet, 0);
        enable = 1'b1;
        push(10, 6, 4, 0);
        drain("re-enable");

        // Pending load right before reset must be discarded.
        a0 = ack_total;
        cyc(1);
        do_load(4'd9, 4'd4, 4'd9);
        chk("pre-reset ch0 high", int'(pwm_out[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset pwm_out", int'(pwm_out), 0);
        chk("async reset period_end", int'(period_end), 0);
        chk("async reset load_ack", int'(load_ack), 0);
        cyc(2);
        rst_n = 1'b1;
        push(16, 0, 0, 0);
        drain("post reset");
        chk("post reset ack count", ack_total - a0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Multi-channel, parametrised PWM generator: the next generation of the single-channel PWM block used by the slave motor/LED drivers. A shared prescaler and period counter drive CHANNELS independent duty comparators. Duty and period values are double-buffered and committed only at a period boundary, so outputs never glitch mid-period. It sits between the slave's register/command decoder and the output pins, replacing the separate clock-divider plus PWM pairing.

## Interface
- WIDTH, 8: counter, period and per-channel duty width.
- CHANNELS, 4: number of PWM outputs.
- PRESC_W, 8: prescaler width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run/stop for counters and outputs.
- prescale  in  PRESC_W  tick every prescale+1 clk cycles; sampled live.
- period  in  WIDTH  shadow period value; the period is period+1 ticks.
- duty  in  CHANNELS*WIDTH  shadow duties; channel i is bits [i*WIDTH +: WIDTH].
- load  in  1  one-cycle request to capture period and duty into the shadow registers.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_end  out  1  one-cycle pulse on the clk where the counter wraps.
- load_ack  out  1  one-cycle pulse when shadow values become active.

## Operation
- Reset: presc_cnt=0, cnt=0, period_a=all-ones, duty_a=0, shadows=0, pending=0. pwm_out=0, period_end=0, load_ack=0.
- Prescaler:
  - presc_cnt counts 0..prescale and then returns to 0.
  - tick is asserted on the cycle where presc_cnt==prescale.
  - prescale=0 gives a tick every clk.
- Counter, edge-aligned: on each tick, cnt increments. When cnt==period_a, the tick wraps cnt to 0 and asserts period_end.
- Compare: each clk, pwm_out[i] <= enable & (cnt < duty_a[i]). The comparison is unsigned, full WIDTH.
  - duty_a[i]=0 gives a constant low output.
  - duty_a[i] > period_a gives a constant high output.
- Load handshake:
  - When load=1, period and duty are captured into the shadow registers and pending is set.
  - A second load while pending overwrites the shadows. Only one ack is issued.
- Commit: at the wrap tick with pending=1, period_a and duty_a are taken from the shadows, pending clears, and load_ack pulses.
- Simultaneous load and wrap tick: the new values are captured into the shadows, and this same tick commits them.
- enable=0:
  - presc_cnt and cnt are held at 0; pwm_out goes to 0 on the next clk; period_end stays 0.
  - A pending load commits on the next clk, with load_ack pulsing.
- enable 0→1: counting restarts from cnt=0, presc_cnt=0. The first period is a full period.
- Reset mid-operation: all state returns to reset values immediately. A pending load is discarded.

## Timing
- pwm_out lags cnt by 1 clk.
- period_end and load_ack are registered and aligned to the clk following the wrap tick. The new values affect pwm_out from the first cycle of the new period.
- load on cycle N has shadows valid at N+1. load_ack arrives at the first wrap at or after N.
- Period length: (prescale+1)*(period_a+1) clk cycles, edge-aligned.

## Configuration
- PWM_CENTER_ALIGN_EN defined: cnt counts up 0..period_a, then down to 0 (triangle).
  - Period length: 2*period_a ticks; period_a=0 holds cnt at 0.
  - period_end and commit occur at the bottom, when cnt returns to 0.
  - The output is symmetric about the top of the triangle; the high time is 2*duty ticks, clamped to the full period.
- Not defined: edge-aligned sawtooth only, as described above. The direction logic is not synthesised.

## Test plan
- Reset and duty check (WIDTH=4, CHANNELS=2, prescale=0):
  - While rst_n=0: all outputs are 0.
  - Release reset, load period=9, duty={ch1=0, ch0=3}, enable=1.
  - After load_ack, ch0 is high 3 of every 10 clks, ch1 is constantly low, and period_end is 1 cycle every 10.
- Saturation and prescaler: duty ch0=10 > period 9 with prescale=2 → ch0 constant high; period_end every 30 clks.
- Glitch-free update:
  - Change duty to 7 via load mid-period.
  - Required: the current period keeps a 3/10 duty; load_ack coincides with period_end; the next period has 7/10 duty.
- Double load and same-cycle load:
  - Two loads before a wrap (duty 5 then 2) → a single load_ack and duty 2 applied.
  - A load on the wrap tick → committed at that wrap.
- Enable drop:
  - enable=0 mid-period → pwm_out=0 after 1 clk and the counter is frozen at 0.
  - Re-enable → a full first period starting from cnt=0.
- Reset mid-period: drop rst_n while ch0 is high → pwm_out=0 immediately and duty_a=0 after release. With the center-align macro defined, period 4 and duty 2 → 8-clk period with 4 clks high.
